jscan_chain_driver: RTL and testbench

//  Tester-side end of an MSS scan chain: accepts parallel test patterns and serialises

---
 rtl/jscan_pkg.sv | 15 +
 rtl/jscan_piso_sipo.sv | 40 ++++
 rtl/jscan_chain_driver.sv | 159 +++++++++++++++
 tb/tb_jscan_chain_driver.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jscan_pkg.sv
// Shared definitions for the JSCAN tester-side scan chain driver.
// Holds the default chain geometry and the FSM state encoding.
package jscan_pkg;

    localparam int JSCAN_CHAIN_LEN = 8;
    localparam int JSCAN_SEL_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_RESP   = 2'd3
    } jscan_state_e;

endpackage

// File: rtl/jscan_piso_sipo.sv
// Combined load register (parallel in, serial out MSB first) and capture register
// (serial in, parallel out), both advanced by a single shift strobe.
module jscan_piso_sipo #(
    parameter int CHAIN_LEN = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_i,
    input  logic [CHAIN_LEN-1:0] load_val_i,
    input  logic                 shift_i,
    input  logic                 sin_i,
    output logic                 sout_o,
    output logic [CHAIN_LEN-1:0] cap_next_o
);

    logic [CHAIN_LEN-1:0] piso_q;
    // Only the low N-1 captured bits are ever needed: the final word is formed
    // combinationally together with the last serial bit.
    logic [CHAIN_LEN-2:0] sipo_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            piso_q <= '0;
        end else if (load_i) begin
            piso_q <= load_val_i;
        end else if (shift_i) begin
            piso_q <= {piso_q[CHAIN_LEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (shift_i) begin
            sipo_q <= cap_next_o[CHAIN_LEN-2:0];
        end
    end

    assign sout_o     = piso_q[CHAIN_LEN-1];
    assign cap_next_o = {sipo_q, sin_i};

endmodule

// File: rtl/jscan_chain_driver.sv
// Tester-side scan chain driver: serialises each pattern into the selected cluster's
// chain while capturing the previous chain contents and comparing them under a mask.
module jscan_chain_driver
    import jscan_pkg::*;
#(
    parameter int CHAIN_LEN = JSCAN_CHAIN_LEN,
    parameter int SEL_W     = JSCAN_SEL_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    input  logic [CHAIN_LEN-1:0] pat_data,
    input  logic [CHAIN_LEN-1:0] pat_expect,
    input  logic [CHAIN_LEN-1:0] pat_mask,
    input  logic [SEL_W-1:0]     pat_cluster,
    input  logic                 abort,
    output logic                 scan_en,
    output logic                 scan_si,
    output logic [SEL_W-1:0]     cluster_sel,
    input  logic                 scan_so,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [CHAIN_LEN-1:0] rsp_data,
    output logic                 rsp_fail,
    output logic                 busy
);

    localparam int              CNT_W = $clog2(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CHAIN_LEN - 1);

    jscan_state_e         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 scan_en_q, scan_en_d;
    logic [SEL_W-1:0]     cluster_sel_q, cluster_sel_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [CHAIN_LEN-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_fail_q, rsp_fail_d;

    logic [CHAIN_LEN-1:0] pat_data_q, expect_q, mask_q;

    logic                 accept;
    logic                 load;
    logic [CHAIN_LEN-1:0] load_val;
    logic                 shift;
    logic                 sout;
    logic [CHAIN_LEN-1:0] cap_next;

    jscan_piso_sipo #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_piso_sipo (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (load),
        .load_val_i (load_val),
        .shift_i    (shift),
        .sin_i      (scan_so),
        .sout_o     (sout),
        .cap_next_o (cap_next)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        scan_en_d     = scan_en_q;
        cluster_sel_d = cluster_sel_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_fail_d    = rsp_fail_q;
        accept        = 1'b0;
        load          = 1'b0;
        load_val      = pat_data_q;
        shift         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pat_valid) begin
                    accept        = 1'b1;
                    cluster_sel_d = pat_cluster;
                    state_d       = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    scan_en_d = 1'b1;
                    load      = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    // Park scan_si low; the chain itself is left partially shifted.
                    scan_en_d = 1'b0;
                    load      = 1'b1;
                    load_val  = '0;
                    state_d   = ST_IDLE;
                end else begin
                    shift = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        scan_en_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = cap_next;
                        rsp_fail_d  = |((cap_next ^ expect_q) & mask_q);
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            scan_en_q     <= 1'b0;
            cluster_sel_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_fail_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            scan_en_q     <= scan_en_d;
            cluster_sel_q <= cluster_sel_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_fail_q    <= rsp_fail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pat_data_q <= pat_data;
            expect_q   <= pat_expect;
            mask_q     <= pat_mask;
        end
    end

    assign pat_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign scan_en     = scan_en_q;
    assign scan_si     = sout;
    assign cluster_sel = cluster_sel_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_fail    = rsp_fail_q;

endmodule

// File: tb/tb_jscan_chain_driver.sv
// Bench for jscan_chain_driver: models an 8-bit left-shift scan chain on the far side
// and predicts each response from the chain contents the previous pattern left behind.
module tb_jscan_chain_driver;

    localparam int N  = 8;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pat_valid = 1'b0;
    logic          pat_ready;
    logic [N-1:0]  pat_data = '0;
    logic [N-1:0]  pat_expect = '0;
    logic [N-1:0]  pat_mask = '0;
    logic [SW-1:0] pat_cluster = '0;
    logic          abort = 1'b0;
    logic          scan_en;
    logic          scan_si;
    logic [SW-1:0] cluster_sel;
    logic          scan_so;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [N-1:0]  rsp_data;
    logic          rsp_fail;
    logic          busy;

    always #5 clk = ~clk;

    jscan_chain_driver #(.CHAIN_LEN(N), .SEL_W(SW)) dut (
        .clk(clk), .reset_n(reset_n),
        .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_data(pat_data),
        .pat_expect(pat_expect), .pat_mask(pat_mask), .pat_cluster(pat_cluster),
        .abort(abort), .scan_en(scan_en), .scan_si(scan_si), .cluster_sel(cluster_sel),
        .scan_so(scan_so), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_fail(rsp_fail), .busy(busy)
    );

    // Far-side chain (mss_block stand-in): shifts left whenever scan_en is high at an edge.
    logic [N-1:0] chain = '0;
    int           shift_edges = 0;
    always @(posedge clk) begin
        if (scan_en) begin
            chain       <= {chain[N-2:0], scan_si};
            shift_edges <= shift_edges + 1;
        end
    end
    assign scan_so = chain[N-1];

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [N-1:0]  ref_chain = '0;

    int            lat;
    int            en_cnt;
    logic [N-1:0]  si_bits;
    logic [SW-1:0] cl_seen;
    bit            tmo;

    function automatic logic fail_of(input logic [N-1:0] r, e, m);
        return |((r ^ e) & m);
    endfunction

    // Chain contents after k shifts of pattern d into old contents c.
    function automatic logic [N-1:0] partial_load(input logic [N-1:0] c, d, input int k);
        logic [2*N-1:0] w;
        w = {c, d} << k;
        return w[2*N-1:N];
    endfunction

    task automatic offer(input logic [N-1:0] d, e, m, input logic [SW-1:0] c);
        int w;
        w = 0;
        while (!pat_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        pat_valid = 1'b1; pat_data = d; pat_expect = e; pat_mask = m; pat_cluster = c;
        @(posedge clk); #1;
        pat_valid = 1'b0;
    endtask

    // Called one step after the accept edge; records what the chain side saw.
    task automatic observe();
        lat = 0; en_cnt = 0; si_bits = '0; tmo = 1'b1; cl_seen = '0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            lat = i;
            if (i == 1) cl_seen = cluster_sel;
            if (scan_en) begin
                en_cnt++;
                si_bits = {si_bits[N-2:0], scan_si};
            end
            if (rsp_valid) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic ack(input int hold);
        rsp_ready = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({scan_en, scan_si, cluster_sel, rsp_valid, rsp_data, rsp_fail, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b si=%b sel=%0d rv=%b rd=%h rf=%b busy=%b, want all 0",
                     scan_en, scan_si, cluster_sel, rsp_valid, rsp_data, rsp_fail, busy);
        end
        n_cmp++;
        if (pat_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pat_ready: got %b want 1", pat_ready);
        end
    endtask

    task automatic test_fresh_chain();
        offer(8'hA5, 8'h00, 8'hFF, 2'd2);
        observe();
        n_cmp++;
        if (tmo || lat != N + 1) begin
            n_fail++;
            $display("FAIL fresh_latency: got %0d (timeout=%0b) want %0d", lat, tmo, N + 1);
        end
        n_cmp++;
        if (cl_seen !== 2'd2) begin
            n_fail++;
            $display("FAIL fresh_cluster_sel: got %0d want 2", cl_seen);
        end
        n_cmp++;
        if (si_bits !== 8'hA5 || en_cnt != N) begin
            n_fail++;
            $display("FAIL fresh_scan_si: got bits %h en_cycles %0d want A5 / %0d", si_bits, en_cnt, N);
        end
        n_cmp++;
        if (rsp_data !== ref_chain || rsp_fail !== fail_of(ref_chain, 8'h00, 8'hFF)) begin
            n_fail++;
            $display("FAIL fresh_rsp: got %h/%b want %h/%b", rsp_data, rsp_fail,
                     ref_chain, fail_of(ref_chain, 8'h00, 8'hFF));
        end
        ack(0);
        ref_chain = 8'hA5;
        n_cmp++;
        if (rsp_valid !== 1'b0 || chain !== ref_chain) begin
            n_fail++;
            $display("FAIL fresh_after_ack: got rv=%b chain=%h want rv=0 chain=%h", rsp_valid, chain, ref_chain);
        end
    endtask

    task automatic test_compare();
        logic [N-1:0] pats [3] = '{8'h3C, 8'hA5, 8'h3C};
        logic [N-1:0] exps [3] = '{8'hA4, 8'h00, 8'hA4};
        logic [N-1:0] msks [3] = '{8'hFF, 8'h00, 8'hFE};
        for (int k = 0; k < 3; k++) begin
            offer(pats[k], exps[k], msks[k], SW'(k + 1));
            observe();
            n_cmp++;
            if (tmo || rsp_data !== ref_chain || rsp_fail !== fail_of(ref_chain, exps[k], msks[k])) begin
                n_fail++;
                $display("FAIL compare_%0d: got %h/%b want %h/%b", k, rsp_data, rsp_fail,
                         ref_chain, fail_of(ref_chain, exps[k], msks[k]));
            end
            ack(0);
            ref_chain = pats[k];
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] d0;
        logic         f0;
        offer(8'h5A, 8'h3C, 8'hF0, 2'd1);
        observe();
        n_cmp++;
        if (tmo || rsp_data !== ref_chain || rsp_fail !== fail_of(ref_chain, 8'h3C, 8'hF0)) begin
            n_fail++;
            $display("FAIL bp_rsp: got %h/%b want %h/%b", rsp_data, rsp_fail,
                     ref_chain, fail_of(ref_chain, 8'h3C, 8'hF0));
        end
        ref_chain = 8'h5A;
        d0 = rsp_data; f0 = rsp_fail;
        pat_valid = 1'b1; pat_data = 8'hC3; pat_expect = 8'h5A; pat_mask = 8'hFF; pat_cluster = 2'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({rsp_valid, rsp_data, rsp_fail, pat_ready} !== {1'b1, d0, f0, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got rv=%b rd=%h rf=%b pr=%b want 1/%h/%b/0",
                         i, rsp_valid, rsp_data, rsp_fail, pat_ready, d0, f0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || pat_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_handshake: got rv=%b pr=%b want 0/1", rsp_valid, pat_ready);
        end
        @(posedge clk); #1;
        pat_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || pat_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_accept: got busy=%b pr=%b want 1/0", busy, pat_ready);
        end
        observe();
        n_cmp++;
        if (tmo || lat != N + 1 || cl_seen !== 2'd3 || rsp_data !== ref_chain
            || rsp_fail !== fail_of(ref_chain, 8'h5A, 8'hFF)) begin
            n_fail++;
            $display("FAIL bp_second: got lat=%0d sel=%0d %h/%b want %0d/3 %h/%b", lat, cl_seen,
                     rsp_data, rsp_fail, N + 1, ref_chain, fail_of(ref_chain, 8'h5A, 8'hFF));
        end
        ack(2);
        ref_chain = 8'hC3;
    endtask

    task automatic test_abort();
        int  se0;
        bit  saw_rsp;
        offer(8'h96, 8'h00, 8'hFF, 2'd0);
        se0 = shift_edges;
        repeat (3) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_cmp++;
        if (scan_en !== 1'b0 || pat_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stop: got en=%b pr=%b busy=%b want 0/1/0", scan_en, pat_ready, busy);
        end
        n_cmp++;
        if (shift_edges - se0 != 3) begin
            n_fail++;
            $display("FAIL abort_shift_edges: got %0d want 3", shift_edges - se0);
        end
        saw_rsp = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (rsp_valid) saw_rsp = 1'b1;
        end
        n_cmp++;
        if (saw_rsp) begin
            n_fail++;
            $display("FAIL abort_no_rsp: got rsp_valid=1 want 0");
        end
        ref_chain = partial_load(ref_chain, 8'h96, 3);
        n_cmp++;
        if (chain !== ref_chain) begin
            n_fail++;
            $display("FAIL abort_chain: got %h want %h", chain, ref_chain);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [N-1:0] d;
        offer(8'h71, 8'h00, 8'hFF, 2'd1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (scan_en !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_drop: got en=%b rv=%b busy=%b want 0/0/0", scan_en, rsp_valid, busy);
        end
        ref_chain = partial_load(ref_chain, 8'h71, 1);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        d = N'($urandom);
        offer(d, 8'hFF, 8'h0F, 2'd2);
        observe();
        n_cmp++;
        if (tmo || lat != N + 1 || en_cnt != N || si_bits !== d || rsp_data !== ref_chain
            || rsp_fail !== fail_of(ref_chain, 8'hFF, 8'h0F)) begin
            n_fail++;
            $display("FAIL rst_mid_recover: got lat=%0d en=%0d si=%h %h/%b want %0d/%0d/%h %h/%b",
                     lat, en_cnt, si_bits, rsp_data, rsp_fail, N + 1, N, d,
                     ref_chain, fail_of(ref_chain, 8'hFF, 8'h0F));
        end
        ack(0);
        ref_chain = d;
    endtask

    task automatic test_random();
        logic [N-1:0]  d, e, m;
        logic [SW-1:0] c;
        for (int i = 0; i < 20; i++) begin
            d = N'($urandom);
            m = N'($urandom);
            e = ($urandom_range(0, 1) == 0) ? ref_chain : N'($urandom);
            c = SW'($urandom);
            offer(d, e, m, c);
            observe();
            n_cmp++;
            if (tmo || lat != N + 1 || cl_seen !== c || si_bits !== d || en_cnt != N
                || rsp_data !== ref_chain || rsp_fail !== fail_of(ref_chain, e, m)) begin
                n_fail++;
                $display("FAIL random_%0d: got lat=%0d sel=%0d si=%h %h/%b want %0d/%0d/%h %h/%b",
                         i, lat, cl_seen, si_bits, rsp_data, rsp_fail, N + 1, c, d,
                         ref_chain, fail_of(ref_chain, e, m));
            end
            ack($urandom_range(0, 3));
            ref_chain = d;
        end
    endtask

    initial begin
        test_reset();
        test_fresh_chain();
        test_compare();
        test_backpressure();
        test_abort();
        test_reset_mid_shift();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
